// File: rtl/dengine_frame_tx.sv
// Framed 32-bit stream transmitter: a word FIFO is drained as frames of a commanded length.
// The last beat is flagged, completed frames are counted, and mid-frame starvation is recorded as a sticky underrun.
module dengine_frame_tx #(
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [LWIDTH-1:0] cfg_len,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [31:0]       o_data,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              clear_flags,
  output logic              busy,
  output logic              underrun,
  output logic [LWIDTH-1:0] frames_sent,
  output logic [AWIDTH:0]   fifo_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [AWIDTH:0]   L_FULL     = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0]   L_CNT_ONE  = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH-1:0] L_PTR_ONE  = AWIDTH'(1);
  localparam logic [LWIDTH-1:0] L_LEN_ONE  = LWIDTH'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic [LWIDTH-1:0] r_len;
  logic [LWIDTH-1:0] r_beat;
  logic [LWIDTH-1:0] r_frames;
  logic              r_underrun;

  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_done;
  logic w_starve;

  assign wr_ready    = (r_count != L_FULL);
  assign cfg_ready   = (r_state == S_IDLE);
  assign busy        = (r_state == S_SEND);
  assign o_valid     = (r_state == S_SEND) && (r_count != '0);
  assign o_data      = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_last      = o_valid && (r_beat == (r_len - L_LEN_ONE));
  assign underrun    = r_underrun;
  assign frames_sent = r_frames;
  assign fifo_count  = r_count;

  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = o_valid && i_ready;
  assign w_starve = (r_state == S_SEND) && (r_count == '0) && (r_beat != '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_valid && (cfg_len != '0)) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (w_pop && o_last) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_len  <= '0;
      r_beat <= '0;
    end else begin
      if (w_load) begin
        r_len  <= cfg_len;
        r_beat <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + L_LEN_ONE;
      end
    end
  end

  // Clear has priority over a coincident frame completion or starvation.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_frames   <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (clear_flags) begin
        r_frames <= '0;
      end else if (w_done) begin
        r_frames <= r_frames + L_LEN_ONE;
      end
      if (clear_flags) begin
        r_underrun <= 1'b0;
      end else if (w_starve) begin
        r_underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dengine_frame_tx.sv
// Self-checking bench for dengine_frame_tx: a queue-based frame model is compared every cycle,
// with directed scenarios pinning literal values and a randomized phase for broad coverage.
module tb_dengine_frame_tx;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = 16;

  logic          clk = 1'b0;
  logic          rstf = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [31:0]   o_data;
  logic          o_last;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          clear_flags = 1'b0;
  logic          busy;
  logic          underrun;
  logic [LW-1:0] frames_sent;
  logic [AW:0]   fifo_count;

  always #5 clk = ~clk;

  dengine_frame_tx #(.AWIDTH(AW), .DEPTH(DEPTH), .LWIDTH(LW)) dut (
    .clk         (clk),
    .rstf        (rstf),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .cfg_len     (cfg_len),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .clear_flags (clear_flags),
    .busy        (busy),
    .underrun    (underrun),
    .frames_sent (frames_sent),
    .fifo_count  (fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word queue plus frame bookkeeping.
  logic [31:0] m_q[$];
  bit          m_send;
  int          m_len;
  int          m_beat;
  logic [15:0] m_frames;
  bit          m_under;

  // Captured handshakes (data, last flag, cycle index).
  logic [31:0] cap_d[$];
  bit          cap_l[$];
  int          cap_c[$];
  int          cyc = 0;

  bit          hold_v;
  logic [31:0] hold_d;
  logic        hold_l;

  bit m_pop, m_push, m_last, m_was_send, m_starve;

  function automatic bit m_valid();
    return m_send && (m_q.size() != 0);
  endfunction

  function automatic logic [31:0] m_head();
    return m_valid() ? m_q[0] : 32'h0;
  endfunction

  function automatic bit m_is_last();
    return m_valid() && (m_beat == m_len - 1);
  endfunction

  always @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      m_q.delete();
      m_send   = 1'b0;
      m_len    = 0;
      m_beat   = 0;
      m_frames = '0;
      m_under  = 1'b0;
      hold_v   = 1'b0;
    end else begin
      cyc++;
      hold_v = o_valid && !i_ready;
      hold_d = o_data;
      hold_l = o_last;
      if (o_valid && i_ready) begin
        cap_d.push_back(o_data);
        cap_l.push_back(o_last);
        cap_c.push_back(cyc);
      end
      m_was_send = m_send;
      m_pop      = m_valid() && i_ready;
      m_last     = m_pop && m_is_last();
      m_push     = wr_valid && (m_q.size() < DEPTH);
      m_starve   = m_send && (m_q.size() == 0) && (m_beat != 0);
      if (m_pop) begin
        void'(m_q.pop_front());
        m_beat++;
        if (m_last) begin
          m_send = 1'b0;
          m_frames++;
        end
      end
      if (m_push) m_q.push_back(wr_data);
      if (!m_was_send && cfg_valid && (cfg_len != '0)) begin
        m_send = 1'b1;
        m_len  = int'(cfg_len);
        m_beat = 0;
      end
      if (clear_flags) begin
        m_under  = 1'b0;
        m_frames = '0;
      end else if (m_starve) begin
        m_under = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rstf) begin
      check("o_valid",     32'(o_valid),     32'(m_valid()));
      check("o_data",      o_data,           m_head());
      check("o_last",      32'(o_last),      32'(m_is_last()));
      check("wr_ready",    32'(wr_ready),    32'(m_q.size() != DEPTH));
      check("cfg_ready",   32'(cfg_ready),   32'(!m_send));
      check("busy",        32'(busy),        32'(m_send));
      check("underrun",    32'(underrun),    32'(m_under));
      check("frames_sent", 32'(frames_sent), 32'(m_frames));
      check("fifo_count",  32'(fifo_count),  32'(m_q.size()));
      if (hold_v) begin
        check("hold_data", o_data,        hold_d);
        check("hold_last", 32'(o_last),   32'(hold_l));
        check("hold_valid", 32'(o_valid), 32'h1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_valid    = 1'b0;
    cfg_valid   = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_l.delete();
    cap_c.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstf = 1'b0;
    idle_inputs();
    i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstf = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_ready"},    32'(wr_ready),    32'h1);
    check({tag, "_cfg_ready"},   32'(cfg_ready),   32'h1);
    check({tag, "_o_valid"},     32'(o_valid),     32'h0);
    check({tag, "_o_last"},      32'(o_last),      32'h0);
    check({tag, "_o_data"},      o_data,           32'h0);
    check({tag, "_busy"},        32'(busy),        32'h0);
    check({tag, "_underrun"},    32'(underrun),    32'h0);
    check({tag, "_frames_sent"}, 32'(frames_sent), 32'h0);
    check({tag, "_fifo_count"},  32'(fifo_count),  32'h0);
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic command(input int len);
    cfg_valid = 1'b1;
    cfg_len   = LW'(len);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check("wait_idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] base, input int n);
    check({tag, "_beats"}, 32'(cap_d.size()), 32'(n));
    for (int i = 0; i < n && i < cap_d.size(); i++) begin
      check({tag, "_data"}, cap_d[i], base + 32'(i));
      check({tag, "_last"}, 32'(cap_l[i]), 32'(i == n - 1));
    end
  endtask

  logic [31:0] rnd_words[5];
  int          n_last;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and a plain 4-beat frame.
    do_reset();
    check_reset_vals("reset");
    push_words(32'h11, 4);
    check("prefill_count", 32'(fifo_count), 32'h4);
    i_ready = 1'b1;
    clear_caps();
    command(4);
    wait_idle(20);
    check_frame("frame4", 32'h11, 4);
    for (int i = 1; i < cap_c.size(); i++)
      check("frame4_consecutive", 32'(cap_c[i] - cap_c[0]), 32'(i));
    check("frame4_frames_sent", 32'(frames_sent), 32'h1);
    check("frame4_busy", 32'(busy), 32'h0);

    // Empty-FIFO start, late words, underrun and clear.
    clear_caps();
    command(3);
    repeat (3) step();
    check("empty_start_valid", 32'(o_valid), 32'h0);
    check("empty_start_underrun", 32'(underrun), 32'h0);
    wr_valid = 1'b1;
    wr_data  = 32'hA0;
    step();
    wr_data  = 32'hA1;
    check("late_push_valid", 32'(o_valid), 32'h1);
    check("late_push_data", o_data, 32'hA0);
    check("late_push_underrun", 32'(underrun), 32'h0);
    step();
    wr_valid = 1'b0;
    step();
    step();
    check("starved_underrun", 32'(underrun), 32'h1);
    wr_valid = 1'b1;
    wr_data  = 32'hA2;
    step();
    wr_valid = 1'b0;
    wait_idle(10);
    check_frame("frame3", 32'hA0, 3);
    check("frame3_frames_sent", 32'(frames_sent), 32'h2);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("clear_underrun", 32'(underrun), 32'h0);
    check("clear_frames_sent", 32'(frames_sent), 32'h0);

    // Fill to full, overflow attempt, then a 16-beat frame with pushes each cycle.
    do_reset();
    i_ready = 1'b0;
    push_words(32'h100, 16);
    check("full_wr_ready", 32'(wr_ready), 32'h0);
    check("full_count", 32'(fifo_count), 32'd16);
    wr_valid = 1'b1;
    wr_data  = 32'h1FF;
    step();
    wr_valid = 1'b0;
    check("overflow_count", 32'(fifo_count), 32'd16);
    clear_caps();
    i_ready   = 1'b1;
    cfg_valid = 1'b1;
    cfg_len   = LW'(16);
    wr_valid  = 1'b1;
    wr_data   = 32'h200;
    step();
    cfg_valid = 1'b0;
    for (int k = 1; k < 40 && busy; k++) begin
      wr_data = 32'h200 + 32'(k);
      step();
    end
    wr_valid = 1'b0;
    check_frame("frame16", 32'h100, 16);
    check("frame16_leftover", 32'(fifo_count), 32'd15);
    clear_caps();
    command(15);
    wait_idle(40);
    check_frame("frame15", 32'h202, 15);

    // 5-beat frame under random backpressure.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rnd_words[i] = $urandom;
      wr_valid = 1'b1;
      wr_data  = rnd_words[i];
      step();
    end
    wr_valid = 1'b0;
    clear_caps();
    command(5);
    for (int k = 0; k < 200 && busy; k++) begin
      i_ready = 1'($urandom_range(0, 1));
      step();
    end
    i_ready = 1'b0;
    check("bp_timeout", 32'(busy), 32'h0);
    check("bp_beats", 32'(cap_d.size()), 32'd5);
    n_last = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      if (i < 5) check("bp_data", cap_d[i], rnd_words[i]);
      if (cap_l[i]) n_last++;
    end
    check("bp_last_count", 32'(n_last), 32'h1);

    // Zero-length command, command while busy, reset mid-frame.
    do_reset();
    push_words(32'h300, 2);
    i_ready = 1'b1;
    clear_caps();
    command(0);
    repeat (3) step();
    check("len0_busy", 32'(busy), 32'h0);
    check("len0_count", 32'(fifo_count), 32'h2);
    check("len0_beats", 32'(cap_d.size()), 32'h0);
    check("len0_frames", 32'(frames_sent), 32'h0);
    i_ready = 1'b0;
    command(3);
    cfg_valid = 1'b1;
    cfg_len   = LW'(2);
    repeat (2) step();
    cfg_valid = 1'b0;
    push_words(32'h302, 1);
    i_ready = 1'b1;
    wait_idle(20);
    check_frame("busy_cmd", 32'h300, 3);
    check("busy_cmd_frames", 32'(frames_sent), 32'h1);
    repeat (2) step();
    check("busy_cmd_idle", 32'(busy), 32'h0);
    push_words(32'h400, 4);
    i_ready = 1'b0;
    command(4);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("midframe_valid", 32'(o_valid), 32'h1);
    check("midframe_data", o_data, 32'h401);
    #2;
    rstf = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    rstf = 1'b1;
    step();
    check("post_reset_count", 32'(fifo_count), 32'h0);
    check("post_reset_busy", 32'(busy), 32'h0);

    // Randomized traffic; every cycle is checked against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      wr_valid    = ($urandom_range(0, 9) < 6);
      wr_data     = $urandom;
      i_ready     = ($urandom_range(0, 3) != 0);
      cfg_valid   = ($urandom_range(0, 7) == 0);
      cfg_len     = LW'($urandom_range(0, 8));
      clear_flags = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();
    i_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
